// File: rtl/col_sense_ctrl.sv
// Column-side access sequencer: precharge, self-timed evaluate, sense, result handshake, write window.
// Optional read accumulator enabled by defining SENSE_ACC_EN.
module col_sense_ctrl #(
   parameter int unsigned PRE_CYCLES   = 2,
   parameter int unsigned EVAL_TIMEOUT = 8,
   parameter int unsigned WR_CYCLES    = 3,
   parameter int unsigned ACC_W        = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             w_en,
   input  logic             MAC_en,
   input  logic             read_bar,
   input  logic             BL_dummy,
   input  logic [3:0]       SA_out,
   input  logic [3:0]       ML,
   input  logic             out_ready,
`ifdef SENSE_ACC_EN
   input  logic             acc_clr,
   output logic [ACC_W-1:0] acc,
`endif
   output logic             PRE_b,
   output logic             SAE,
   output logic             busy,
   output logic             out_valid,
   output logic [3:0]       dout,
   output logic [2:0]       mac_sum,
   output logic [3:0]       match,
   output logic             hit,
   output logic [1:0]       hit_addr,
   output logic             err,
   output logic             wr_done
);

   localparam int unsigned M1      = (PRE_CYCLES > WR_CYCLES) ? PRE_CYCLES : WR_CYCLES;
   localparam int unsigned CNT_MAX = (M1 > EVAL_TIMEOUT) ? M1 : EVAL_TIMEOUT;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_CYCLES - 1);
   localparam logic [CNT_W-1:0] EVAL_LAST = CNT_W'(EVAL_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] WR_LAST   = CNT_W'(WR_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, PRECH, EVAL, SENSE, HOLD, WRITE} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             sync1, sync2;
   logic             lat_mac, lat_rbar;
   logic             err_set;
   logic [3:0]       rdata;
   logic [2:0]       rsum;
   logic             capture;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         sync1 <= BL_dummy;
         sync2 <= sync1;
      end
   end

   // A synced BL_dummy arriving on the final timeout cycle still counts as a clean evaluate.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      err_set   = 1'b0;
      unique case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (start) state_nxt = w_en ? WRITE : PRECH;
         end
         PRECH: begin
            if (cnt == PRE_LAST) begin
               state_nxt = EVAL;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         EVAL: begin
            if (sync2) begin
               state_nxt = SENSE;
               cnt_nxt   = '0;
            end else if (cnt == EVAL_LAST) begin
               state_nxt = SENSE;
               cnt_nxt   = '0;
               err_set   = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         SENSE: state_nxt = HOLD;
         HOLD: begin
            if (out_ready) state_nxt = IDLE;
         end
         WRITE: begin
            if (cnt == WR_LAST) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign PRE_b     = (state != PRECH);
   assign SAE       = (state == SENSE);
   assign busy      = (state != IDLE);
   assign out_valid = (state == HOLD);
   assign wr_done   = (state == WRITE) && (cnt == WR_LAST);

   assign rdata   = lat_rbar ? ~SA_out : SA_out;
   assign rsum    = 3'(rdata[0]) + 3'(rdata[1]) + 3'(rdata[2]) + 3'(rdata[3]);
   assign capture = (state == SENSE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_mac  <= 1'b0;
         lat_rbar <= 1'b0;
         err      <= 1'b0;
         dout     <= '0;
         mac_sum  <= '0;
         match    <= '0;
         hit      <= 1'b0;
         hit_addr <= '0;
      end else begin
         if (state == IDLE && start) begin
            lat_mac  <= MAC_en;
            lat_rbar <= read_bar;
            err      <= 1'b0;
         end else if (err_set) begin
            err <= 1'b1;
         end
         if (capture) begin
            if (lat_mac) begin
               dout    <= rdata;
               mac_sum <= rsum;
            end else begin
               match    <= ML;
               hit      <= |ML;
               hit_addr <= ML[0] ? 2'd0 : ML[1] ? 2'd1 : ML[2] ? 2'd2 : ML[3] ? 2'd3 : 2'd0;
            end
         end
      end
   end

`ifdef SENSE_ACC_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (capture && lat_mac) begin
         acc <= acc_clr ? ACC_W'(rsum) : acc + ACC_W'(rsum);
      end else if (acc_clr) begin
         acc <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_col_sense_ctrl.sv
// Directed self-checking bench for col_sense_ctrl (accumulator checks only when SENSE_ACC_EN is defined).
module tb_col_sense_ctrl;
   logic       clk = 1'b0;
   logic       rst_n, start, w_en, MAC_en, read_bar, BL_dummy, out_ready;
   logic [3:0] SA_out, ML;
   logic       PRE_b, SAE, busy, out_valid, hit, err, wr_done;
   logic [3:0] dout, match;
   logic [2:0] mac_sum;
   logic [1:0] hit_addr;
`ifdef SENSE_ACC_EN
   logic       acc_clr;
   logic [2:0] acc;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int pre_n, eval_n, sae_n, excl_bad;
   int busy_n, done_at, ov_seen, sae_seen;

   always #5 clk = ~clk;

`ifdef SENSE_ACC_EN
   col_sense_ctrl #(.ACC_W(3)) dut (
`else
   col_sense_ctrl dut (
`endif
      .clk(clk), .rst_n(rst_n), .start(start), .w_en(w_en), .MAC_en(MAC_en),
      .read_bar(read_bar), .BL_dummy(BL_dummy), .SA_out(SA_out), .ML(ML),
      .out_ready(out_ready),
`ifdef SENSE_ACC_EN
      .acc_clr(acc_clr), .acc(acc),
`endif
      .PRE_b(PRE_b), .SAE(SAE), .busy(busy), .out_valid(out_valid), .dout(dout),
      .mac_sum(mac_sum), .match(match), .hit(hit), .hit_addr(hit_addr), .err(err),
      .wr_done(wr_done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_access(input logic mac, input logic rb, input int bl_delay,
                             output int p_n, output int e_n, output int s_n, output int x_bad);
      start = 1'b1; w_en = 1'b0; MAC_en = mac; read_bar = rb;
      tick();
      start = 1'b0;
      p_n = 0; x_bad = 0;
      for (int i = 0; i < 20 && !PRE_b; i++) begin
         p_n++;
         if (SAE) x_bad++;
         tick();
      end
      e_n = 0;
      for (int i = 0; i < 40 && !SAE; i++) begin
         if (e_n == bl_delay) BL_dummy = 1'b1;
         e_n++;
         tick();
      end
      s_n = 0;
      for (int i = 0; i < 5 && SAE; i++) begin
         s_n++;
         if (!PRE_b) x_bad++;
         tick();
      end
      BL_dummy = 1'b0;
   endtask

   task automatic release_hold();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("release_valid", out_valid, 0);
      check("release_busy", busy, 0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_preb"}, PRE_b, 1);
      check({tag, "_sae"}, SAE, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_valid"}, out_valid, 0);
      check({tag, "_dout"}, dout, 0);
      check({tag, "_sum"}, mac_sum, 0);
      check({tag, "_match"}, match, 0);
      check({tag, "_hit"}, {hit, hit_addr}, 0);
      check({tag, "_err"}, err, 0);
      check({tag, "_wrdone"}, wr_done, 0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; w_en = 1'b0; MAC_en = 1'b0; read_bar = 1'b0;
      BL_dummy = 1'b0; out_ready = 1'b0; SA_out = '0; ML = '0;
`ifdef SENSE_ACC_EN
      acc_clr = 1'b0;
`endif
      tick(); tick();
      check_reset_vals("rst");
      rst_n = 1'b1;
      tick();

      // Plain read
      SA_out = 4'b1011;
      run_access(1'b1, 1'b0, 2, pre_n, eval_n, sae_n, excl_bad);
      check("rd_pre_cycles", pre_n, 2);
      check("rd_eval_cycles", eval_n, 5);
      check("rd_sae_cycles", sae_n, 1);
      check("rd_exclusive", excl_bad, 0);
      check("rd_valid", out_valid, 1);
      check("rd_dout", dout, 4'b1011);
      check("rd_sum", mac_sum, 3);
      check("rd_err", err, 0);
      check("rd_match_kept", match, 0);
      release_hold();

      // Complement read
      run_access(1'b1, 1'b1, 2, pre_n, eval_n, sae_n, excl_bad);
      check("crd_dout", dout, 4'b0100);
      check("crd_sum", mac_sum, 1);
      release_hold();

      // CAM searches
      ML = 4'b1100;
      run_access(1'b0, 1'b0, 0, pre_n, eval_n, sae_n, excl_bad);
      check("cam_eval_cycles", eval_n, 3);
      check("cam_match", match, 4'b1100);
      check("cam_hit", hit, 1);
      check("cam_addr", hit_addr, 2);
      check("cam_dout_kept", dout, 4'b0100);
      check("cam_sum_kept", mac_sum, 1);
      release_hold();
      ML = 4'b0110;
      run_access(1'b0, 1'b0, 0, pre_n, eval_n, sae_n, excl_bad);
      check("cam2_addr", hit_addr, 1);
      release_hold();
      ML = 4'b0000;
      run_access(1'b0, 1'b0, 0, pre_n, eval_n, sae_n, excl_bad);
      check("cam0_match", match, 0);
      check("cam0_hit", hit, 0);
      check("cam0_addr", hit_addr, 0);
      release_hold();

      // EVAL timeout, then err cleared by next start
      SA_out = 4'b0001;
      run_access(1'b1, 1'b0, -1, pre_n, eval_n, sae_n, excl_bad);
      check("to_eval_cycles", eval_n, 8);
      check("to_err", err, 1);
      check("to_dout", dout, 4'b0001);
      release_hold();
      check("to_err_held", err, 1);
      SA_out = 4'b0111;
      run_access(1'b1, 1'b0, 4, pre_n, eval_n, sae_n, excl_bad);
      check("late_eval_cycles", eval_n, 7);
      check("late_err_cleared", err, 0);
      check("late_sum", mac_sum, 3);

      // Stalled consumer: result stable, start ignored
      SA_out = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         start = 1'b1; w_en = 1'b1;
         tick();
         check("stall_valid", out_valid, 1);
         check("stall_dout", dout, 4'b0111);
         check("stall_busy", busy, 1);
      end
      out_ready = 1'b1;
      tick();
      check("hs_start_ignored", busy, 0);
      check("hs_valid_drop", out_valid, 0);
      start = 1'b0; out_ready = 1'b0;
      tick();
      check("hs_idle", busy, 0);

      // Write window
      start = 1'b1; w_en = 1'b1;
      tick();
      start = 1'b0; w_en = 1'b0;
      busy_n = 0; done_at = 0; ov_seen = 0; sae_seen = 0;
      for (int i = 0; i < 10 && busy; i++) begin
         busy_n++;
         if (wr_done) done_at = busy_n;
         if (out_valid) ov_seen++;
         if (SAE || !PRE_b) sae_seen++;
         tick();
      end
      check("wr_busy_cycles", busy_n, 3);
      check("wr_done_cycle", done_at, 3);
      check("wr_no_valid", ov_seen, 0);
      check("wr_no_sae_pre", sae_seen, 0);
      check("wr_done_clear", wr_done, 0);

      // Reset during EVAL
      ML = 4'b1000;
      run_access(1'b0, 1'b0, 0, pre_n, eval_n, sae_n, excl_bad);
      check("pre_rst_addr", hit_addr, 3);
      release_hold();
      start = 1'b1; w_en = 1'b0; MAC_en = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      check("mid_in_eval", {busy, PRE_b, SAE}, 3'b110);
      rst_n = 1'b0;
      #1;
      check_reset_vals("midrst");
      tick();
      rst_n = 1'b1;
      tick();

`ifdef SENSE_ACC_EN
      check("acc_rst", acc, 0);
      SA_out = 4'b1111;
      run_access(1'b1, 1'b0, 0, pre_n, eval_n, sae_n, excl_bad);
      check("acc_first", acc, 4);
      release_hold();
      run_access(1'b1, 1'b0, 0, pre_n, eval_n, sae_n, excl_bad);
      check("acc_wrap", acc, 0);
      release_hold();
      run_access(1'b1, 1'b0, 0, pre_n, eval_n, sae_n, excl_bad);
      check("acc_again", acc, 4);
      acc_clr = 1'b1;
      tick();
      acc_clr = 1'b0;
      check("acc_clr", acc, 0);
      release_hold();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
